// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
// MULT_SIGNED_EN (defined elsewhere) selects two's-complement operation in the top.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Step counter must reach WIDTH-1; one spare bit keeps WIDTH a power of two safe.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the multiplier's add/subtract row.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mult_add_row.sv
// N-bit ripple add/subtract row: sum = x + y, or x - y when sub is high.
// The carry out of the top bit is never needed, so the MSB is a sum-only stage.
module mult_add_row #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] y_eff;
  logic [N-1:0] carry;

  // Subtraction as x + ~y + 1: invert y and inject sub as the carry in.
  assign y_eff    = y ^ {N{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < N - 1; i++) begin : g_bit
    full_adder u_fa (
      .a  (x[i]),
      .b  (y_eff[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign sum[N-1] = x[N-1] ^ y_eff[N-1] ^ carry[N-1];

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one operand pair in, one 2*WIDTH product out after WIDTH steps.
// Define MULT_SIGNED_EN for two's-complement operands and product; unsigned otherwise.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int             CW        = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       row_x;
  logic [WIDTH:0]       row_y;
  logic                 row_sub;
  logic [WIDTH:0]       row_sum;
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   acc_next;

`ifdef MULT_SIGNED_EN
  // Upper accumulator and multiplicand sign-extend; the multiplier's sign bit weighs -2^(W-1).
  assign row_x   = {acc[2*WIDTH-1], acc[2*WIDTH-1:WIDTH]};
  assign row_y   = {mcand[WIDTH-1], mcand};
  assign row_sub = (cnt == LAST_STEP);
`else
  assign row_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
  assign row_y   = {1'b0, mcand};
  assign row_sub = 1'b0;
`endif

  mult_add_row #(
    .N (WIDTH + 1)
  ) u_row (
    .x   (row_x),
    .y   (row_y),
    .sub (row_sub),
    .sum (row_sum)
  );

  // The extra sum bit lands in the MSB, so the shift keeps the carry (or sign).
  assign step_sum = acc[0] ? row_sum : row_x;
  assign acc_next = {step_sum, acc[WIDTH-1:1]};

  // NOTE: every register, including the datapath, resets so an aborted product leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      mcand     <= '0;
      cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= a;
            acc      <= {{WIDTH{1'b0}}, b};
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            p         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
